// File: rtl/alarm_pkg.sv
// Shared state and timer-interval codes for the lab 4 car alarm.
// Imported by the alarm FSM, time_parameters and timer.
package alarm_pkg;

    localparam logic [2:0] ARMED           = 3'd0;
    localparam logic [2:0] TRIGGERED       = 3'd1;
    localparam logic [2:0] SOUND_ALARM     = 3'd2;
    localparam logic [2:0] ALARM_HOLD      = 3'd3;
    localparam logic [2:0] DISARMED        = 3'd4;
    localparam logic [2:0] WAIT_DOOR_OPEN  = 3'd5;
    localparam logic [2:0] WAIT_DOOR_CLOSE = 3'd6;
    localparam logic [2:0] ARM_DELAY       = 3'd7;

    localparam logic [1:0] T_ARM_DELAY       = 2'b00;
    localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
    localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
    localparam logic [1:0] T_ALARM_ON        = 2'b11;

    function automatic logic is_timed(input logic [2:0] s);
        return (s == TRIGGERED) || (s == ALARM_HOLD) || (s == ARM_DELAY);
    endfunction

    function automatic logic is_loud(input logic [2:0] s);
        return (s == SOUND_ALARM) || (s == ALARM_HOLD);
    endfunction

endpackage

// File: rtl/fuel_pump_ctrl.sv
// Fuel pump power latch: ignition off kills the pump, hidden switch
// plus brake enables it, otherwise it holds.
module fuel_pump_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ignition_i,
    input  logic hidden_switch_i,
    input  logic brake_i,
    output logic fuel_pump_o
);

    logic pump_q, pump_d;

    always_comb begin
        pump_d = pump_q;
        if (!ignition_i)
            pump_d = 1'b0;
        else if (hidden_switch_i && brake_i)
            pump_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pump_q <= 1'b0;
        else       pump_q <= pump_d;
    end

    assign fuel_pump_o = pump_q;

endmodule

// File: rtl/anti_theft_fsm.sv
// Car alarm control FSM with registered outputs.
// Define SIREN_TONE_EN for a 440/880 Hz square-wave siren instead of a level.
module anti_theft_fsm #(
    parameter int SIREN_HALF_PERIOD = 28409
) (
    input  logic       clock_25mhz,
    input  logic       reset_sync,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       hidden_switch,
    input  logic       brake_depressed,
    input  logic       one_hz_enable,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       status_led,
    output logic       siren,
    output logic       fuel_pump,
    output logic [2:0] state
);
    import alarm_pkg::*;

    logic [2:0] state_q, state_d;
    logic [1:0] interval_q, interval_d;
    logic       start_q, start_d;
    logic       led_q, led_d;
    logic       siren_q, siren_d;
    logic       any_door, exp_v, loud_d;

    assign any_door = driver_door | passenger_door;
    // The timer is restarting this cycle, so its expired is stale.
    assign exp_v    = expired & ~start_q;

    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        unique case (state_q)
            ARMED: begin
                if (ignition) state_d = DISARMED;
                else if (driver_door) begin
                    state_d    = TRIGGERED;
                    interval_d = T_DRIVER_DELAY;
                end else if (passenger_door) begin
                    state_d    = TRIGGERED;
                    interval_d = T_PASSENGER_DELAY;
                end
            end
            TRIGGERED: begin
                if (ignition)   state_d = DISARMED;
                else if (exp_v) state_d = SOUND_ALARM;
            end
            SOUND_ALARM: begin
                if (ignition) state_d = DISARMED;
                else if (!any_door) begin
                    state_d    = ALARM_HOLD;
                    interval_d = T_ALARM_ON;
                end
            end
            ALARM_HOLD: begin
                if (ignition)      state_d = DISARMED;
                else if (any_door) state_d = SOUND_ALARM;
                else if (exp_v)    state_d = ARMED;
            end
            DISARMED: begin
                if (!ignition) state_d = WAIT_DOOR_OPEN;
            end
            WAIT_DOOR_OPEN: begin
                if (ignition)         state_d = DISARMED;
                else if (driver_door) state_d = WAIT_DOOR_CLOSE;
            end
            WAIT_DOOR_CLOSE: begin
                if (ignition) state_d = DISARMED;
                else if (!any_door) begin
                    state_d    = ARM_DELAY;
                    interval_d = T_ARM_DELAY;
                end
            end
            ARM_DELAY: begin
                if (ignition)      state_d = DISARMED;
                else if (any_door) state_d = WAIT_DOOR_CLOSE;
                else if (exp_v)    state_d = ARMED;
            end
        endcase
    end

    assign start_d = is_timed(state_d) && (state_d != state_q);
    assign loud_d  = is_loud(state_d);

    always_comb begin
        led_d = 1'b0;
        unique case (state_d)
            ARMED:
                led_d = (state_q != ARMED) ? 1'b0 : (led_q ^ one_hz_enable);
            TRIGGERED, SOUND_ALARM, ALARM_HOLD:
                led_d = 1'b1;
            DISARMED, WAIT_DOOR_OPEN, WAIT_DOOR_CLOSE, ARM_DELAY:
                led_d = 1'b0;
        endcase
    end

`ifdef SIREN_TONE_EN
    localparam logic [14:0] HP_440 = 15'(SIREN_HALF_PERIOD);
    localparam logic [14:0] HP_880 = 15'(SIREN_HALF_PERIOD / 2);

    logic [14:0] cnt_q, cnt_d;
    logic        pitch_q, pitch_d;
    logic [14:0] hp;

    assign hp = pitch_q ? HP_880 : HP_440;

    always_comb begin
        cnt_d   = '0;
        pitch_d = 1'b0;
        siren_d = 1'b0;
        if (loud_d && !is_loud(state_q)) begin
            siren_d = 1'b1;
        end else if (loud_d) begin
            pitch_d = pitch_q ^ one_hz_enable;
            siren_d = siren_q;
            if (cnt_q >= hp - 15'd1) begin
                siren_d = ~siren_q;
            end else begin
                cnt_d = cnt_q + 15'd1;
            end
        end
    end

    always_ff @(posedge clock_25mhz or posedge reset_sync) begin
        if (reset_sync) begin
            cnt_q   <= '0;
            pitch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pitch_q <= pitch_d;
        end
    end
`else
    assign siren_d = loud_d;
`endif

    always_ff @(posedge clock_25mhz or posedge reset_sync) begin
        if (reset_sync) begin
            state_q    <= ARMED;
            interval_q <= T_ARM_DELAY;
            start_q    <= 1'b0;
            led_q      <= 1'b0;
            siren_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            start_q    <= start_d;
            led_q      <= led_d;
            siren_q    <= siren_d;
        end
    end

    fuel_pump_ctrl u_fuel_pump (
        .clk_i           (clock_25mhz),
        .rst_i           (reset_sync),
        .ignition_i      (ignition),
        .hidden_switch_i (hidden_switch),
        .brake_i         (brake_depressed),
        .fuel_pump_o     (fuel_pump)
    );

    assign state       = state_q;
    assign interval    = interval_q;
    assign start_timer = start_q;
    assign status_led  = led_q;
    assign siren       = siren_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm (default build, steady siren).
module tb_anti_theft_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       ign, drv, pas, hid, brk, hz, exp_p;
    logic       start_timer, status_led, siren, fuel_pump;
    logic [1:0] interval;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    always #20 clk = ~clk;

    anti_theft_fsm dut (
        .clock_25mhz     (clk),
        .reset_sync      (rst),
        .ignition        (ign),
        .driver_door     (drv),
        .passenger_door  (pas),
        .hidden_switch   (hid),
        .brake_depressed (brk),
        .one_hz_enable   (hz),
        .expired         (exp_p),
        .start_timer     (start_timer),
        .interval        (interval),
        .status_led      (status_led),
        .siren           (siren),
        .fuel_pump       (fuel_pump),
        .state           (state)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_hz();
        hz = 1'b1; tick(); hz = 1'b0;
    endtask

    task automatic pulse_exp();
        exp_p = 1'b1; tick(); exp_p = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {ign, drv, pas, hid, brk, hz, exp_p} = '0;
        repeat (2) tick();
        check("rst_state", state, 0);
        check("rst_outs", {start_timer, interval, status_led, siren, fuel_pump}, 0);
        rst = 1'b0;

        // idle armed: LED blinks, no timer start
        repeat (3) begin
            tick();
            check("idle_start", start_timer, 0);
        end
        check("idle_state", state, 0);
        check("idle_led0", status_led, 0);
        pulse_hz();
        check("led_hz1", status_led, 1);
        tick();
        check("led_hold", status_led, 1);
        pulse_hz();
        check("led_hz2", status_led, 0);

        // driver door triggers
        drv = 1'b1; tick();
        check("trig_state", state, 1);
        check("trig_intv", interval, 2'b01);
        check("trig_start", start_timer, 1);
        check("trig_led", status_led, 1);
        tick();
        check("trig_start_off", start_timer, 0);
        check("trig_hold", state, 1);
        pulse_exp();
        check("sound_state", state, 2);
        check("sound_siren", siren, 1);
        tick();
        check("sound_stay", state, 2);

        // close doors -> hold, reopen -> sound
        drv = 1'b0; tick();
        check("hold_state", state, 3);
        check("hold_intv", interval, 2'b11);
        check("hold_start", start_timer, 1);
        check("hold_siren", siren, 1);
        tick();
        check("hold_start_off", start_timer, 0);
        pas = 1'b1; tick();
        check("reopen_state", state, 2);
        pas = 1'b0; tick();
        check("rehold_state", state, 3);
        check("rehold_start", start_timer, 1);
        // expired while start_timer high is ignored
        pulse_exp();
        check("exp_ignored", state, 3);
        pulse_exp();
        check("rearm_state", state, 0);
        check("rearm_siren", siren, 0);
        check("rearm_led", status_led, 0);

        // passenger trigger, then ignition beats expired
        pas = 1'b1; tick();
        check("ptrig_state", state, 1);
        check("ptrig_intv", interval, 2'b10);
        pas = 1'b0; tick();
        ign = 1'b1; exp_p = 1'b1; tick(); exp_p = 1'b0;
        check("ign_wins", state, 4);
        check("ign_siren", siren, 0);
        check("dis_led", status_led, 0);

        // disarm-to-arm sequence
        ign = 1'b0; tick();
        check("wopen_state", state, 5);
        drv = 1'b1; tick();
        check("wclose_state", state, 6);
        drv = 1'b0; tick();
        check("adelay_state", state, 7);
        check("adelay_intv", interval, 2'b00);
        check("adelay_start", start_timer, 1);
        tick();
        pas = 1'b1; tick();
        check("adelay_back", state, 6);
        pas = 1'b0; tick();
        check("adelay2_state", state, 7);
        check("adelay2_start", start_timer, 1);
        tick();
        check("adelay2_off", start_timer, 0);
        pulse_exp();
        check("armed_again", state, 0);

        // fuel pump latch
        ign = 1'b1; hid = 1'b1; brk = 1'b0; tick();
        check("fp_no_brake", fuel_pump, 0);
        brk = 1'b1; tick();
        check("fp_on", fuel_pump, 1);
        hid = 1'b0; brk = 1'b0; tick();
        check("fp_hold", fuel_pump, 1);
        ign = 1'b0; tick();
        check("fp_ign_off", fuel_pump, 0);
        ign = 1'b1; hid = 1'b1; brk = 1'b1; tick();
        check("fp_on2", fuel_pump, 1);
        check("fp_state", state, 4);

        // asynchronous reset mid-run
        #5 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_outs", {start_timer, interval, status_led, siren, fuel_pump}, 0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
